// File: rtl/clk_pulse_gen.sv
// clk_pulse_gen: divides in_clk into a 50% slow clock level with one-cycle edge-announce pulses
//   in_clk  - main clock, all state on its rising edge
//   in_rst  - asynchronous active-high reset
//   out_clk - registered slow clock level
//   out_re  - high in the cycle before out_clk rises
//   out_fe  - high in the cycle before out_clk falls
module clk_pulse_gen #(
  parameter longint MAIN_CLK_HZ = 50_000_000,
  parameter longint CLK_HZ = 10_000,
  parameter bit CLK_INIT = 1'b1
) (
  input  logic in_clk,
  input  logic in_rst,
  output logic out_clk,
  output logic out_re,
  output logic out_fe
);
  localparam longint HALF_RAW = MAIN_CLK_HZ / CLK_HZ / 2;
  localparam longint HALF = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CTR_MAX = CW'(HALF - 1);
  logic [CW-1:0] ctr_q, ctr_d;
  logic clk_q, clk_d;
  logic wrap;
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ctr_q <= '0;
      clk_q <= CLK_INIT;
    end else begin
      ctr_q <= ctr_d;
      clk_q <= clk_d;
    end
  end
  always_comb begin
    wrap = ctr_q == CTR_MAX;
    ctr_d = wrap ? '0 : ctr_q + 1'b1;
    clk_d = wrap ? ~clk_q : clk_q;
  end
  // pulses are gated by reset because with HALF=1 the reset counter already equals CTR_MAX
  assign out_clk = clk_q;
  assign out_re = wrap & ~clk_q & ~in_rst;
  assign out_fe = wrap & clk_q & ~in_rst;
endmodule

// File: tb/tb_clk_pulse_gen.sv
// tb_clk_pulse_gen: scoreboard bench over four divider configurations
module tb_clk_pulse_gen;
  logic clk = 1'b0;
  logic rst_g = 1'b1;
  logic rst_a = 1'b1;
  logic [2:0] obs [4];
  logic c0, r0, f0, c1, r1, f1, c2, r2, f2, c3, r3, f3;
  int errors = 0;
  int checks = 0;
  typedef struct {int id; logic [2:0] v;} exp_t;
  exp_t sb[$];
  int half [4] = '{5, 5, 1, 2500};
  bit init [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  string nm [4] = '{"div5_init1", "div5_init0", "div1", "div2500"};
  int n [4] = '{0, 0, 0, 0};
  int re_cnt = 0;
  int fe_cnt = 0;
  localparam int N = 20003;

  always #5 clk = ~clk;

  clk_pulse_gen #(.MAIN_CLK_HZ(10), .CLK_HZ(1), .CLK_INIT(1'b1)) u0 (
    .in_clk(clk), .in_rst(rst_a), .out_clk(c0), .out_re(r0), .out_fe(f0));
  clk_pulse_gen #(.MAIN_CLK_HZ(10), .CLK_HZ(1), .CLK_INIT(1'b0)) u1 (
    .in_clk(clk), .in_rst(rst_g), .out_clk(c1), .out_re(r1), .out_fe(f1));
  clk_pulse_gen #(.MAIN_CLK_HZ(2), .CLK_HZ(1), .CLK_INIT(1'b1)) u2 (
    .in_clk(clk), .in_rst(rst_g), .out_clk(c2), .out_re(r2), .out_fe(f2));
  clk_pulse_gen #(.MAIN_CLK_HZ(50_000_000), .CLK_HZ(10_000), .CLK_INIT(1'b1)) u3 (
    .in_clk(clk), .in_rst(rst_g), .out_clk(c3), .out_re(r3), .out_fe(f3));

  assign obs[0] = {c0, r0, f0};
  assign obs[1] = {c1, r1, f1};
  assign obs[2] = {c2, r2, f2};
  assign obs[3] = {c3, r3, f3};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // expected {clk, re, fe} for cycle n after release: level flips every half cycles,
  // the announcing pulse sits in the last cycle of each half period
  function automatic logic [2:0] model(input int h, input bit ini, input bit r, input int k);
    logic c;
    logic w;
    if (r) return {ini, 2'b00};
    c = ini ^ ((k / h) % 2 == 1);
    w = (k % h) == h - 1;
    return {c, w & ~c, w & c};
  endfunction

  initial begin
    for (int cyc = 0; cyc < N; cyc++) begin
      @(posedge clk);
      #1;
      rst_g = cyc < 3;
      rst_a = cyc < 3 || (cyc >= 10 && cyc < 12);
      for (int i = 0; i < 4; i++) begin
        bit r;
        r = (i == 0) ? rst_a : rst_g;
        sb.push_back('{i, model(half[i], init[i], r, n[i])});
        n[i] = r ? 0 : n[i] + 1;
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("%s@%0d", nm[e.id], cyc), 32'(obs[e.id]), 32'(e.v));
      end
      chk($sformatf("excl@%0d", cyc), 32'((r0 & f0) | (r1 & f1) | (r2 & f2) | (r3 & f3)), 32'd0);
      re_cnt += int'(r3);
      fe_cnt += int'(f3);
    end
    chk("div2500_re_count", 32'(re_cnt), 32'd4);
    chk("div2500_fe_count", 32'(fe_cnt), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
